// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the registered 1-to-4 nibble demultiplexer.
package demux_pkg;

  localparam int LANES  = 4;
  localparam int SEL_W  = 2;
  localparam int LANE_W = 4;

  typedef logic [LANE_W-1:0] lane_t;

  function automatic logic [LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/nibble_lane_reg.sv
// One output lane: a W-bit holding register with synchronous reset and write enable.
module nibble_lane_reg #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/four_bit_1to4_demux_reg.sv
// Registered 1-to-4 nibble demux with explicit or round-robin lane selection,
// a written-lane mask and a one-cycle pulse whenever all four lanes are filled.
module four_bit_1to4_demux_reg
  import demux_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [W-1:0]     d,
  input  logic             load,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto_mode,
  input  logic             restart,
  output logic [4*W-1:0]   q,
  output logic [LANES-1:0] written,
  output logic [SEL_W-1:0] ptr,
  output logic             frame_done
);

  logic [SEL_W-1:0] r_ptr;
  logic [LANES-1:0] r_written;
  logic             r_frame_done;

  logic [SEL_W-1:0] w_target;
  logic             w_write;
  logic [LANES-1:0] w_nw;

  assign w_target = auto_mode ? r_ptr : sel;
  assign w_write  = load & ~restart;
  assign w_nw     = r_written | onehot4(w_target);

  // Lane data is only cleared by reset; restart keeps the last assembled word.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic w_en;
    assign w_en = w_write & (w_target == SEL_W'(gi));

    nibble_lane_reg #(
      .W(W)
    ) u_lane (
      .i_clk (CLOCK_50),
      .i_srst(reset),
      .i_en  (w_en),
      .i_d   (d),
      .o_q   (q[W*gi +: W])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || restart) begin
      r_ptr        <= '0;
      r_written    <= '0;
      r_frame_done <= 1'b0;
    end else if (load) begin
      if (auto_mode) begin
        r_ptr <= r_ptr + 1'b1;
      end
      // A completed mask is consumed immediately so the next frame starts empty.
      if (w_nw == 4'b1111) begin
        r_written    <= '0;
        r_frame_done <= 1'b1;
      end else begin
        r_written    <= w_nw;
        r_frame_done <= 1'b0;
      end
    end else begin
      r_frame_done <= 1'b0;
    end
  end

  assign written    = r_written;
  assign ptr        = r_ptr;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_four_bit_1to4_demux_reg.sv
// Bench for four_bit_1to4_demux_reg: directed vector table, then random traffic vs. a lane-array model.
module tb_four_bit_1to4_demux_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  d = '0;
  logic        load = 1'b0;
  logic [1:0]  sel = '0;
  logic        auto_mode = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] q;
  logic [3:0]  written;
  logic [1:0]  ptr;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  four_bit_1to4_demux_reg dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .d         (d),
    .load      (load),
    .sel       (sel),
    .auto_mode (auto_mode),
    .restart   (restart),
    .q         (q),
    .written   (written),
    .ptr       (ptr),
    .frame_done(frame_done)
  );

  typedef struct {
    logic        rst;
    logic        ld;
    logic [3:0]  dd;
    logic [1:0]  sl;
    logic        am;
    logic        rs;
    logic [15:0] e_q;
    logic [3:0]  e_w;
    logic [1:0]  e_p;
    logic        e_f;
  } vec_t;

  vec_t vecs[$];

  // Reference state: lane values, set of filled lanes, round-robin position.
  int  m_lane[4];
  bit  m_filled[4];
  int  m_ptr;
  bit  m_done;

  function automatic vec_t mk(logic rst, logic ld, logic [3:0] dd, logic [1:0] sl, logic am,
                              logic rs, logic [15:0] e_q, logic [3:0] e_w, logic [1:0] e_p,
                              logic e_f);
    vec_t v;
    v.rst = rst; v.ld = ld; v.dd = dd; v.sl = sl; v.am = am; v.rs = rs;
    v.e_q = e_q; v.e_w = e_w; v.e_p = e_p; v.e_f = e_f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic ld, input logic [3:0] dd,
                            input logic [1:0] sl, input logic am, input logic rs);
    int t;
    int cnt;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin m_lane[k] = 0; m_filled[k] = 0; end
      m_ptr = 0; m_done = 0;
    end else if (rs) begin
      for (int k = 0; k < 4; k++) m_filled[k] = 0;
      m_ptr = 0; m_done = 0;
    end else if (ld) begin
      t = am ? m_ptr : int'(sl);
      m_lane[t] = int'(dd);
      m_filled[t] = 1;
      if (am) m_ptr = (m_ptr + 1) % 4;
      cnt = 0;
      for (int k = 0; k < 4; k++) cnt += m_filled[k];
      if (cnt == 4) begin
        for (int k = 0; k < 4; k++) m_filled[k] = 0;
        m_done = 1;
      end else begin
        m_done = 0;
      end
    end else begin
      m_done = 0;
    end
  endtask

  function automatic int model_q();
    return m_lane[0] + 16 * m_lane[1] + 256 * m_lane[2] + 4096 * m_lane[3];
  endfunction

  function automatic int model_w();
    return m_filled[0] + 2 * m_filled[1] + 4 * m_filled[2] + 8 * m_filled[3];
  endfunction

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic drive_cycle(input logic rst, input logic ld, input logic [3:0] dd,
                             input logic [1:0] sl, input logic am, input logic rs);
    reset = rst; load = ld; d = dd; sel = sl; auto_mode = am; restart = rs;
    @(posedge clk);
    #1;
    model_step(rst, ld, dd, sl, am, rs);
  endtask

  initial begin
    // rst ld d sel am rs | q w ptr fd
    vecs.push_back(mk(1, 1, 4'hF, 0, 0, 0, 16'h0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 0, 0, 0, 16'h0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 2, 0, 0, 16'h0A00, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 16'h0A00, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'h0A00, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 0, 1, 0, 16'h0A01, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 1, 4'h2, 0, 1, 0, 16'h0A21, 4'b0011, 2, 0));
    vecs.push_back(mk(0, 1, 4'h3, 0, 1, 0, 16'h0321, 4'b0111, 3, 0));
    vecs.push_back(mk(0, 1, 4'h4, 0, 1, 0, 16'h4321, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0, 16'h4321, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 16'h0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'h5, 0, 0, 0, 16'h0005, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 4'h6, 0, 0, 0, 16'h0006, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 4'h7, 1, 0, 0, 16'h0076, 4'b0011, 0, 0));
    vecs.push_back(mk(0, 1, 4'h8, 2, 0, 0, 16'h0876, 4'b0111, 0, 0));
    vecs.push_back(mk(0, 1, 4'h9, 3, 0, 0, 16'h9876, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 16'h9876, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 0, 1, 0, 16'h9871, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 1, 4'h2, 0, 1, 0, 16'h9821, 4'b0011, 2, 0));
    vecs.push_back(mk(0, 1, 4'hC, 0, 1, 1, 16'h9821, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'h3, 0, 1, 0, 16'h9823, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 16'h9823, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 0, 1, 0, 16'h982A, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 1, 4'hB, 0, 1, 0, 16'h98BA, 4'b0011, 2, 0));
    vecs.push_back(mk(0, 1, 4'hC, 0, 1, 0, 16'h9CBA, 4'b0111, 3, 0));
    vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0, 16'h0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'hE, 0, 1, 0, 16'h000E, 4'b0001, 1, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].ld, vecs[i].dd, vecs[i].sl, vecs[i].am, vecs[i].rs);
      $display("vec %0d: rst=%0b ld=%0b d=%h sel=%0d am=%0b rs=%0b -> q=%h w=%b p=%0d fd=%0b",
               i, vecs[i].rst, vecs[i].ld, vecs[i].dd, vecs[i].sl, vecs[i].am, vecs[i].rs,
               q, written, ptr, frame_done);
      check("vec_q", 32'(q), 32'(vecs[i].e_q));
      check("vec_written", 32'(written), 32'(vecs[i].e_w));
      check("vec_ptr", 32'(ptr), 32'(vecs[i].e_p));
      check("vec_frame_done", 32'(frame_done), 32'(vecs[i].e_f));
    end

    for (int n = 0; n < 400; n++) begin
      logic r_rst, r_ld, r_am, r_rs;
      logic [3:0] r_d;
      logic [1:0] r_sel;
      r_rst = ($urandom_range(0, 49) == 0);
      r_rs  = ($urandom_range(0, 29) == 0);
      r_ld  = ($urandom_range(0, 3) != 0);
      r_am  = ($urandom_range(0, 2) != 0);
      r_d   = 4'($urandom);
      r_sel = 2'($urandom);
      drive_cycle(r_rst, r_ld, r_d, r_sel, r_am, r_rs);
      $display("rnd %0d: rst=%0b ld=%0b d=%h sel=%0d am=%0b rs=%0b -> q=%h w=%b p=%0d fd=%0b",
               n, r_rst, r_ld, r_d, r_sel, r_am, r_rs, q, written, ptr, frame_done);
      check("rnd_q", 32'(q), 32'(model_q()));
      check("rnd_written", 32'(written), 32'(model_w()));
      check("rnd_ptr", 32'(ptr), 32'(m_ptr));
      check("rnd_frame_done", 32'(frame_done), 32'(m_done));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
